// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed packet transmitter.
package usb_pkg;

   typedef enum logic [2:0] {
      OUT   = 3'd0,
      IN    = 3'd1,
      DATA0 = 3'd2,
      DATA1 = 3'd3,
      ACK   = 3'd4,
      NAK   = 3'd5,
      STALL = 3'd6,
      NONE  = 3'd7
   } tx_packet_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_DATA,
      ST_CRC,
      ST_EOP_SE0,
      ST_EOP_J,
      ST_ERROR
   } tx_state_t;

   localparam logic [7:0]  SYNC_BYTE  = 8'h80;
   localparam logic [7:0]  PID_DATA0  = 8'hC3;
   localparam logic [7:0]  PID_DATA1  = 8'h4B;
   localparam logic [7:0]  PID_ACK    = 8'hD2;
   localparam logic [7:0]  PID_NAK    = 8'h5A;
   localparam logic [7:0]  PID_STALL  = 8'h1E;
   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_SEED = 16'hFFFF;

   function automatic logic [7:0] pid_of(input tx_packet_t pkt);
      logic [7:0] pid;
      case (pkt)
         DATA0:   pid = PID_DATA0;
         DATA1:   pid = PID_DATA1;
         ACK:     pid = PID_ACK;
         NAK:     pid = PID_NAK;
         STALL:   pid = PID_STALL;
         default: pid = 8'h00;
      endcase
      return pid;
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (x^16+x^15+x^2+1), one payload bit per enable, LSB-first input.
module usb_crc16 (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);
   import usb_pkg::*;

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) crc_q <= CRC16_SEED;
      else        crc_q <= crc_d;
   end

   always_comb begin
      fb    = bit_in ^ crc_q[15];
      crc_d = crc_q;
      if (clr)     crc_d = CRC16_SEED;
      else if (en) crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   end

   assign crc = crc_q;

endmodule

// File: rtl/usb_tx.sv
// USB 1.1 full-speed device transmitter: SYNC, PID, payload, CRC16, EOP with NRZI and bit stuffing.
//   state      | meaning
//   ST_IDLE    | line J, waiting for an armed request
//   ST_SYNC    | sending the SYNC byte
//   ST_PID     | sending the PID byte
//   ST_DATA    | sending payload bytes popped from the FIFO
//   ST_CRC     | sending the inverted CRC16
//   ST_EOP_SE0 | two bit times of SE0
//   ST_EOP_J   | one bit time of J, then back to idle
//   ST_ERROR   | one-clock stop after a data request with an empty FIFO
module usb_tx (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] tx_packet,
   input  logic [7:0] tx_packet_data,
   input  logic [6:0] buffer_occupancy,
   output logic       dp_out,
   output logic       dm_out,
   output logic       tx_transfer_active,
   output logic       tx_error,
   output logic       get_tx_packet_data
);
   import usb_pkg::*;

   tx_state_t   state_q, state_d;
   tx_packet_t  req;
   logic [3:0]  tmr_q, tmr_d;
   logic [1:0]  phase_q, phase_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  ones_q, ones_d;
   logic [7:0]  pid_q, pid_d;
   logic [7:0]  byte_q, byte_d;
   logic        is_data_q, is_data_d;
   logic        armed_q, armed_d;
   logic        err_q, err_d;
   logic        get_q, get_d;
   logic        dp_q, dp_d;
   logic        dm_q, dm_d;
   logic        accept, req_data, fifo_empty, strobe, stuff, cur_bit, line_nxt, field_done;
   logic        crc_clr, crc_en;
   logic [15:0] crc;

   assign req        = tx_packet_t'(tx_packet);
   assign req_data   = (req == DATA0) || (req == DATA1);
   assign fifo_empty = (buffer_occupancy == 7'd0);
   assign accept     = (state_q == ST_IDLE) && armed_q && (req inside {DATA0, DATA1, ACK, NAK, STALL});
   assign strobe     = (state_q != ST_IDLE) && (state_q != ST_ERROR) && (tmr_q == 4'd0);
   // six ones already on the line force a toggle before anything else, including SE0
   assign stuff      = (ones_q == 3'd6) && (state_q != ST_EOP_J);
   assign field_done = (state_q == ST_CRC) ? (bit_cnt_q == 4'd15) : (bit_cnt_q[2:0] == 3'd7);
   assign line_nxt   = cur_bit ? dp_q : ~dp_q;
   assign crc_clr    = (state_q == ST_IDLE);
   assign crc_en     = strobe && !stuff && (state_q == ST_DATA);

   always_comb begin
      case (state_q)
         ST_SYNC: cur_bit = SYNC_BYTE[bit_cnt_q[2:0]];
         ST_PID:  cur_bit = pid_q[bit_cnt_q[2:0]];
         ST_DATA: cur_bit = byte_q[bit_cnt_q[2:0]];
         ST_CRC:  cur_bit = ~crc[4'd15 - bit_cnt_q];
         default: cur_bit = 1'b1;
      endcase
   end

   usb_crc16 u_crc (
      .clk    (clk),
      .n_rst  (n_rst),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (cur_bit),
      .crc    (crc)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= ST_IDLE;
         tmr_q     <= 4'd0;
         phase_q   <= 2'd0;
         bit_cnt_q <= 4'd0;
         ones_q    <= 3'd0;
         pid_q     <= 8'h00;
         byte_q    <= 8'h00;
         is_data_q <= 1'b0;
         armed_q   <= 1'b1;
         err_q     <= 1'b0;
         get_q     <= 1'b0;
         dp_q      <= 1'b1;
         dm_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         ones_q    <= ones_d;
         pid_q     <= pid_d;
         byte_q    <= byte_d;
         is_data_q <= is_data_d;
         armed_q   <= armed_d;
         err_q     <= err_d;
         get_q     <= get_d;
         dp_q      <= dp_d;
         dm_q      <= dm_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      ones_d    = ones_q;
      pid_d     = pid_q;
      byte_d    = byte_q;
      is_data_d = is_data_q;
      armed_d   = armed_q;
      err_d     = err_q;
      get_d     = 1'b0;
      dp_d      = dp_q;
      dm_d      = dm_q;
      if (req == NONE) armed_d = 1'b1;
      if (get_q)       byte_d  = tx_packet_data;
      case (state_q)
         ST_IDLE: begin
            tmr_d     = 4'd0;
            phase_d   = 2'd0;
            bit_cnt_d = 4'd0;
            ones_d    = 3'd0;
            dp_d      = 1'b1;
            dm_d      = 1'b0;
            if (accept) begin
               armed_d   = 1'b0;
               err_d     = 1'b0;
               pid_d     = pid_of(req);
               is_data_d = req_data;
               if (req_data && fifo_empty) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_SYNC;
               end
            end
         end
         ST_ERROR: state_d = ST_IDLE;
         default: begin
            if (!strobe) begin
               tmr_d = tmr_q - 4'd1;
            end else begin
               // 8, 8, 9 clocks per bit gives 12 Mb/s on average from 100 MHz
               tmr_d   = (phase_q == 2'd2) ? 4'd8 : 4'd7;
               phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
               if (stuff) begin
                  dp_d   = ~dp_q;
                  dm_d   = dp_q;
                  ones_d = 3'd0;
               end else if (state_q == ST_EOP_SE0) begin
                  dp_d      = 1'b0;
                  dm_d      = 1'b0;
                  ones_d    = 3'd0;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd1) begin
                     bit_cnt_d = 4'd0;
                     state_d   = ST_EOP_J;
                  end
               end else if (state_q == ST_EOP_J) begin
                  dp_d      = 1'b1;
                  dm_d      = 1'b0;
                  bit_cnt_d = 4'd1;
                  if (bit_cnt_q == 4'd1) state_d = ST_IDLE;
               end else begin
                  dp_d      = line_nxt;
                  dm_d      = ~line_nxt;
                  ones_d    = cur_bit ? ones_q + 3'd1 : 3'd0;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (field_done) begin
                     bit_cnt_d = 4'd0;
                     case (state_q)
                        ST_SYNC: state_d = ST_PID;
                        ST_PID, ST_DATA: begin
                           if (!is_data_q) begin
                              state_d = ST_EOP_SE0;
                           end else if (!fifo_empty) begin
                              get_d   = 1'b1;
                              state_d = ST_DATA;
                           end else begin
                              state_d = ST_CRC;
                           end
                        end
                        default: state_d = ST_EOP_SE0;
                     endcase
                  end
               end
            end
         end
      endcase
   end

   always_comb begin
      tx_transfer_active = (state_q != ST_IDLE) && (state_q != ST_ERROR);
      tx_error           = err_q;
      get_tx_packet_data = get_q;
      dp_out             = dp_q;
      dm_out             = dm_q;
   end

endmodule

// File: tb/tb_usb_tx.sv
// Bench for usb_tx: decodes the D+/D- line back to bits and compares against a byte-level packet model.
module tb_usb_tx;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [2:0] tx_packet;
   logic [7:0] tx_packet_data;
   logic [6:0] buffer_occupancy;
   logic       dp_out, dm_out, tx_transfer_active, tx_error, get_tx_packet_data;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         pop_cnt = 0;
   int         fifo_base = 0;
   int         fifo_len = 0;
   logic [7:0] fifo_mem [0:63];
   int         pop_time [0:255];
   logic [1:0] ln_s [0:4095];
   logic       act_s [0:4095];
   int         n_s;
   logic [7:0] payload [$];

   usb_tx dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .tx_packet          (tx_packet),
      .tx_packet_data     (tx_packet_data),
      .buffer_occupancy   (buffer_occupancy),
      .dp_out             (dp_out),
      .dm_out             (dm_out),
      .tx_transfer_active (tx_transfer_active),
      .tx_error           (tx_error),
      .get_tx_packet_data (get_tx_packet_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign buffer_occupancy = 7'(fifo_len - (pop_cnt - fifo_base));
   assign tx_packet_data   = fifo_mem[(pop_cnt - fifo_base) & 63];

   // FIFO model: the byte is taken on the edge that ends the strobe, then the head advances
   always @(negedge clk) begin
      if (get_tx_packet_data === 1'b1) begin
         pop_time[pop_cnt % 256] = cyc;
         @(posedge clk);
         #1;
         pop_cnt = pop_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pid_for(input int code);
      case (code)
         2: return 8'hC3;
         3: return 8'h4B;
         4: return 8'hD2;
         5: return 8'h5A;
         6: return 8'h1E;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [1:0] line_at(input int idx);
      if (idx < 0 || idx >= n_s) return 2'b11;
      return ln_s[idx];
   endfunction

   function automatic int bit_start(input int k);
      return 8 * k + k / 3;
   endfunction

   task automatic load_fifo();
      fifo_base = pop_cnt;
      foreach (payload[i]) fifo_mem[i] = payload[i];
      fifo_len = payload.size();
   endtask

   task automatic rearm();
      @(negedge clk);
      tx_packet = 3'd7;
      repeat (2) @(negedge clk);
   endtask

   task automatic run_packet(input int code, input string name, input bit spacing, input int exp_pay_stuff);
      int         exp_bits [$];
      int         dec [$];
      logic [15:0] crc;
      logic [7:0] b8;
      logic [1:0] prev, ln;
      int n, ones, m_tot, m_pay, d_tot, d_pay, viol, maxrun, run, t0, k, idx, seen, tail, pulses, nb, bv;
      bit stop;
      n = payload.size();
      b8 = 8'h80;
      for (int i = 0; i < 8; i++) exp_bits.push_back(int'(b8[i]));
      b8 = pid_for(code);
      for (int i = 0; i < 8; i++) exp_bits.push_back(int'(b8[i]));
      crc = 16'hFFFF;
      foreach (payload[j]) begin
         b8 = payload[j];
         for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(int'(b8[i]));
            if (crc[0] ^ b8[i]) crc = (crc >> 1) ^ 16'hA001;
            else                crc = crc >> 1;
         end
      end
      if (n > 0) begin
         crc = ~crc;
         for (int i = 0; i < 16; i++) exp_bits.push_back(int'(crc[i]));
      end
      ones = 0; m_tot = 0; m_pay = 0;
      foreach (exp_bits[i]) begin
         ones = exp_bits[i] ? ones + 1 : 0;
         if (ones == 6) begin
            m_tot++;
            if (i >= 16 && i < 16 + 8 * n) m_pay++;
            ones = 0;
         end
      end

      load_fifo();
      @(negedge clk);
      tx_packet = code[2:0];
      n_s = 0; seen = 0; tail = 0;
      while (n_s < 4096 && tail < 12) begin
         @(negedge clk);
         ln_s[n_s]  = {dp_out, dm_out};
         act_s[n_s] = tx_transfer_active;
         if (tx_transfer_active) seen = 1;
         else if (seen != 0) tail++;
         n_s++;
      end
      chk({name, "_complete"}, tail == 12, 1);
      if (tail != 12) return;
      chk({name, "_active_rise"}, act_s[0], 1);

      t0 = -1;
      for (int i = 0; i < n_s; i++) if (t0 < 0 && ln_s[i] != 2'b10) t0 = i;
      chk({name, "_first_bit_latency"}, (t0 >= 0 && t0 <= 2), 1);
      if (t0 < 0) return;

      prev = 2'b10; ones = 0; run = 0; maxrun = 0; viol = 0; d_tot = 0; d_pay = 0; k = 0; stop = 0;
      while (!stop) begin
         idx = t0 + bit_start(k) + 4;
         if (idx >= n_s || k >= 400) begin
            viol++;
            stop = 1;
         end else begin
            ln = ln_s[idx];
            if (ln == 2'b00) begin
               stop = 1;
            end else begin
               if (ln == 2'b11) viol++;
               bv = (ln == prev) ? 1 : 0;
               run = bv ? run + 1 : 0;
               if (run > maxrun) maxrun = run;
               if (ones == 6) begin
                  if (bv != 0) viol++;
                  d_tot++;
                  if (dec.size() > 16 && dec.size() <= 16 + 8 * n) d_pay++;
                  ones = 0;
               end else begin
                  dec.push_back(bv);
                  ones = bv ? ones + 1 : 0;
               end
               prev = ln;
               k++;
            end
         end
      end
      chk({name, "_line_coding"}, viol, 0);
      chk({name, "_max_run"}, maxrun <= 6, 1);
      chk({name, "_eop_se0_1"}, line_at(t0 + bit_start(k) + 4), 2'b00);
      chk({name, "_eop_se0_2"}, line_at(t0 + bit_start(k + 1) + 4), 2'b00);
      chk({name, "_eop_j"}, line_at(t0 + bit_start(k + 2) + 4), 2'b10);
      idx = t0 + bit_start(k + 2) + 4;
      chk({name, "_active_in_j"}, (idx < n_s) ? act_s[idx] : 1'b0, 1);
      idx = t0 + bit_start(k + 3) + 2;
      chk({name, "_active_fall"}, (idx < n_s) ? act_s[idx] : 1'b1, 0);

      chk({name, "_nbits"}, dec.size(), exp_bits.size());
      nb = exp_bits.size() / 8;
      for (int j = 0; j < nb; j++) begin
         logic [7:0] got_b, exp_b;
         got_b = 8'h00; exp_b = 8'h00;
         for (int i = 0; i < 8; i++) begin
            exp_b[i] = exp_bits[8 * j + i][0];
            got_b[i] = (8 * j + i < dec.size()) ? dec[8 * j + i][0] : 1'bx;
         end
         chk($sformatf("%s_byte%0d", name, j), got_b, exp_b);
      end
      chk({name, "_stuff_total"}, d_tot, m_tot);
      chk({name, "_stuff_payload"}, d_pay, m_pay);
      if (exp_pay_stuff >= 0) chk({name, "_stuff_payload_plan"}, d_pay, exp_pay_stuff);

      pulses = pop_cnt - fifo_base;
      chk({name, "_get_pulses"}, pulses, n);
      if (spacing) begin
         for (int j = 1; j < pulses; j++) begin
            int d;
            d = pop_time[(fifo_base + j) % 256] - pop_time[(fifo_base + j - 1) % 256];
            chk($sformatf("%s_get_spacing%0d", name, j), (d >= 64 && d <= 70), 1);
         end
      end
   endtask

   initial begin
      int bad, code, n;
      n_rst     = 1'b0;
      tx_packet = 3'd7;
      #23;
      chk("rst_dp", dp_out, 1);
      chk("rst_dm", dm_out, 0);
      chk("rst_active", tx_transfer_active, 0);
      chk("rst_error", tx_error, 0);
      chk("rst_get", get_tx_packet_data, 0);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      payload.delete();
      run_packet(4, "ack", 0, -1);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (tx_transfer_active) bad++;
      end
      chk("ack_held_no_retrigger", bad, 0);
      rearm();
      run_packet(5, "nak", 0, -1);
      rearm();
      run_packet(6, "stall", 0, -1);
      rearm();

      payload = '{8'h7C};
      run_packet(2, "data0_1b", 0, -1);
      rearm();

      payload.delete();
      for (int i = 1; i <= 10; i++) payload.push_back(8'(i));
      run_packet(3, "data1_10b", 1, -1);
      rearm();

      payload.delete();
      load_fifo();
      @(negedge clk);
      chk("err_before", tx_error, 0);
      tx_packet = 3'd2;
      @(negedge clk);
      chk("err_set", tx_error, 1);
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if ({dp_out, dm_out} != 2'b10 || tx_transfer_active || get_tx_packet_data) bad++;
      end
      chk("err_line_idle", bad, 0);
      rearm();
      chk("err_hold", tx_error, 1);
      run_packet(5, "nak_after_err", 0, -1);
      chk("err_cleared", tx_error, 0);
      rearm();

      payload = '{8'hFF, 8'hFF, 8'hFF};
      run_packet(2, "stuff_ff", 0, 4);
      rearm();

      for (int r = 0; r < 6; r++) begin
         code = $urandom_range(2, 6);
         payload.delete();
         if (code <= 3) begin
            n = $urandom_range(1, 12);
            repeat (n) payload.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
         end
         run_packet(code, $sformatf("rnd%0d", r), 0, -1);
         rearm();
      end

      payload.delete();
      for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
      load_fifo();
      @(negedge clk);
      tx_packet = 3'd2;
      repeat (150) @(negedge clk);
      chk("rst_mid_active", tx_transfer_active, 1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("rst_mid_dp", dp_out, 1);
      chk("rst_mid_dm", dm_out, 0);
      chk("rst_mid_active_low", tx_transfer_active, 0);
      chk("rst_mid_get", get_tx_packet_data, 0);
      tx_packet = 3'd7;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      payload.delete();
      load_fifo();
      repeat (2) @(negedge clk);
      run_packet(4, "ack_after_rst", 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
